// File: rtl/trace_spram_if.sv
// ---------------------------------------------------------------------------
// trace_spram_if : access-port bundle for trace_spram (enable, write enable,
// address, data, output-register enable, read data).
// Honours TRACE_SPRAM_BYTE_WRITE_EN, which widens wea to one bit per byte.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface trace_spram_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 48
);
`ifdef TRACE_SPRAM_BYTE_WRITE_EN
    localparam int WE_WIDTH = DATA_WIDTH / 8;
`else
    localparam int WE_WIDTH = 1;
`endif

    logic                  ena;
    logic [WE_WIDTH-1:0]   wea;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dina;
    logic                  regcea;
    logic [DATA_WIDTH-1:0] douta;

    modport master (output ena, wea, addra, dina, regcea, input douta);
    modport slave  (input ena, wea, addra, dina, regcea, output douta);
endinterface

`default_nettype wire

// File: rtl/trace_spram.sv
// ---------------------------------------------------------------------------
// trace_spram : single-port synchronous RAM with a 1..3 stage read pipeline
// and selectable write-collision behaviour. Optional byte-lane writes are
// enabled by defining TRACE_SPRAM_BYTE_WRITE_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module trace_spram #(
    parameter int                   ADDR_WIDTH       = 10,
    parameter int                   DATA_WIDTH       = 48,
    parameter int                   READ_LATENCY     = 1,
    parameter logic [DATA_WIDTH-1:0] READ_RESET_VALUE = {DATA_WIDTH{1'b1}},
    parameter                       WRITE_MODE       = "no_change"
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    trace_spram_if.slave     bus
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;
`ifdef TRACE_SPRAM_BYTE_WRITE_EN
    localparam int c_WE_W  = DATA_WIDTH / 8;
`else
    localparam int c_WE_W  = 1;
`endif
    localparam int c_MODE  = (WRITE_MODE == "read_first")  ? 1 :
                             (WRITE_MODE == "write_first") ? 2 : 0;

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
            $error("trace_spram: READ_LATENCY must be 1..3");
        end
        if (WRITE_MODE != "no_change" && WRITE_MODE != "read_first" &&
            WRITE_MODE != "write_first") begin : g_bad_mode
            $error("trace_spram: unsupported WRITE_MODE");
        end
`ifdef TRACE_SPRAM_BYTE_WRITE_EN
        if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
            $error("trace_spram: byte writes need DATA_WIDTH to be a multiple of 8");
        end
`endif
    endgenerate

    logic [DATA_WIDTH-1:0] mem_q [c_DEPTH];
    logic [DATA_WIDTH-1:0] out_q;

    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] w_merged;
    logic                  w_we_any;
    logic                  w_s1_load;
    logic [DATA_WIDTH-1:0] w_s1_val;

    assign w_rd_word = mem_q[bus.addra];
    assign w_we_any  = |bus.wea;

`ifdef TRACE_SPRAM_BYTE_WRITE_EN
    // Merged word = stored word with the enabled byte lanes replaced.
    always_comb begin
        w_merged = w_rd_word;
        for (int i = 0; i < c_WE_W; i++) begin
            if (bus.wea[i]) begin
                w_merged[8*i +: 8] = bus.dina[8*i +: 8];
            end
        end
    end
`else
    assign w_merged = bus.dina;
`endif

    // The array has no reset, so writes land even while rst_n is low.
    always_ff @(posedge clk) begin
        if (bus.ena && w_we_any) begin
            mem_q[bus.addra] <= w_merged;
        end
    end

    always_comb begin
        w_s1_load = 1'b0;
        w_s1_val  = w_rd_word;
        if (bus.ena) begin
            if (!w_we_any) begin
                w_s1_load = 1'b1;
            end else if (c_MODE == 1) begin
                w_s1_load = 1'b1;
            end else if (c_MODE == 2) begin
                w_s1_load = 1'b1;
                w_s1_val  = w_merged;
            end
        end
    end

    generate
        if (READ_LATENCY <= 1) begin : g_lat1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_q <= READ_RESET_VALUE;
                end else if (w_s1_load && bus.regcea) begin
                    out_q <= w_s1_val;
                end
            end
        end else begin : g_latn
            logic [DATA_WIDTH-1:0]   stage_q [1:READ_LATENCY-1];
            logic [READ_LATENCY-1:1] en_dly_q;  // bit k: ena delayed by k cycles

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 1; k < READ_LATENCY; k++) begin
                        stage_q[k] <= READ_RESET_VALUE;
                    end
                    en_dly_q <= '0;
                    out_q    <= READ_RESET_VALUE;
                end else begin
                    en_dly_q[1] <= bus.ena;
                    for (int k = 2; k < READ_LATENCY; k++) begin
                        en_dly_q[k] <= en_dly_q[k-1];
                    end
                    if (w_s1_load) begin
                        stage_q[1] <= w_s1_val;
                    end
                    for (int k = 2; k < READ_LATENCY; k++) begin
                        if (en_dly_q[k-1]) begin
                            stage_q[k] <= stage_q[k-1];
                        end
                    end
                    if (en_dly_q[READ_LATENCY-1] && bus.regcea) begin
                        out_q <= stage_q[READ_LATENCY-1];
                    end
                end
            end
        end
    endgenerate

    assign bus.douta = out_q;

endmodule

`default_nettype wire

// File: tb/tb_trace_spram.sv
// ---------------------------------------------------------------------------
// tb_trace_spram : directed bench for trace_spram, driving four instances
// (latency 1 in each write mode, plus latency 2) from one stimulus stream.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_trace_spram;

`ifdef TRACE_SPRAM_BYTE_WRITE_EN
    localparam int c_WEW = 6;
`else
    localparam int c_WEW = 1;
`endif
    localparam logic [47:0] c_ONES = {48{1'b1}};

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             ena   = 1'b0;
    logic [c_WEW-1:0] wea   = '0;
    logic [9:0]       addra = '0;
    logic [47:0]      dina  = '0;
    logic             regcea = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    trace_spram_if #(.ADDR_WIDTH(10), .DATA_WIDTH(48)) bus_nc ();
    trace_spram_if #(.ADDR_WIDTH(10), .DATA_WIDTH(48)) bus_rf ();
    trace_spram_if #(.ADDR_WIDTH(10), .DATA_WIDTH(48)) bus_wf ();
    trace_spram_if #(.ADDR_WIDTH(10), .DATA_WIDTH(48)) bus_l2 ();

    assign bus_nc.ena = ena;  assign bus_nc.wea = wea;  assign bus_nc.addra = addra;
    assign bus_nc.dina = dina; assign bus_nc.regcea = regcea;
    assign bus_rf.ena = ena;  assign bus_rf.wea = wea;  assign bus_rf.addra = addra;
    assign bus_rf.dina = dina; assign bus_rf.regcea = regcea;
    assign bus_wf.ena = ena;  assign bus_wf.wea = wea;  assign bus_wf.addra = addra;
    assign bus_wf.dina = dina; assign bus_wf.regcea = regcea;
    assign bus_l2.ena = ena;  assign bus_l2.wea = wea;  assign bus_l2.addra = addra;
    assign bus_l2.dina = dina; assign bus_l2.regcea = regcea;

    trace_spram #(.READ_LATENCY(1), .WRITE_MODE("no_change"))
        u_nc (.clk(clk), .rst_n(rst_n), .bus(bus_nc));
    trace_spram #(.READ_LATENCY(1), .WRITE_MODE("read_first"))
        u_rf (.clk(clk), .rst_n(rst_n), .bus(bus_rf));
    trace_spram #(.READ_LATENCY(1), .WRITE_MODE("write_first"))
        u_wf (.clk(clk), .rst_n(rst_n), .bus(bus_wf));
    trace_spram #(.READ_LATENCY(2), .WRITE_MODE("no_change"))
        u_l2 (.clk(clk), .rst_n(rst_n), .bus(bus_l2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [47:0] d);
        ena = 1'b1; wea = '1; addra = a; dina = d;
    endtask

    task automatic rd(input logic [9:0] a);
        ena = 1'b1; wea = '0; addra = a;
    endtask

    initial begin
        // Asynchronous reset in the middle of a low clock phase.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_nc", bus_nc.douta, c_ONES);
        chk("rst_async_rf", bus_rf.douta, c_ONES);
        chk("rst_async_wf", bus_wf.douta, c_ONES);
        chk("rst_async_l2", bus_l2.douta, c_ONES);

        // Write while reset is held; release; output stays at reset value.
        wr(10'd9, 48'h0909_0A0B_0C0D);
        tick();
        ena = 1'b0; wea = '0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_nc", bus_nc.douta, c_ONES);
        chk("post_rst_l2", bus_l2.douta, c_ONES);

        rd(10'd9);
        tick();
        chk("wr_in_reset", bus_nc.douta, 48'h0909_0A0B_0C0D);

        // Write then read, latency 1.
        wr(10'd5, 48'h1234_DEAD_BEEF);
        tick();
        rd(10'd5);
        tick();
        chk("wr_rd_nc", bus_nc.douta, 48'h1234_DEAD_BEEF);
        chk("wr_rd_wf", bus_wf.douta, 48'h1234_DEAD_BEEF);

        // Write-collision modes: mem[3]=A, then write B to addr 3.
        wr(10'd3, 48'hAAAA_0000_000A);
        tick();
        rd(10'd5);
        tick();
        wr(10'd3, 48'hBBBB_0000_000B);
        tick();
        chk("mode_no_change",   bus_nc.douta, 48'h1234_DEAD_BEEF);
        chk("mode_read_first",  bus_rf.douta, 48'hAAAA_0000_000A);
        chk("mode_write_first", bus_wf.douta, 48'hBBBB_0000_000B);
        rd(10'd3);
        tick();
        chk("raw_next_cycle", bus_nc.douta, 48'hBBBB_0000_000B);

        // Pipelined reads at latency 2.
        wr(10'd0, 48'h0000_1111_0000); tick();
        wr(10'd1, 48'h0001_2222_0001); tick();
        wr(10'd2, 48'h0002_3333_0002); tick();
        rd(10'd0); tick();
        rd(10'd1); tick();
        chk("pipe_l2_a0", bus_l2.douta, 48'h0000_1111_0000);
        rd(10'd2); tick();
        chk("pipe_l2_a1", bus_l2.douta, 48'h0001_2222_0001);
        ena = 1'b0; tick();
        chk("pipe_l2_a2", bus_l2.douta, 48'h0002_3333_0002);

        // Output register hold with regcea low, then release.
        regcea = 1'b0;
        rd(10'd0); tick();
        tick();
        chk("regcea_hold", bus_l2.douta, 48'h0002_3333_0002);
        regcea = 1'b1;
        tick();
        chk("regcea_release", bus_l2.douta, 48'h0000_1111_0000);

        // Reset while a read is in flight discards it.
        rd(10'd1); tick();
        ena = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_midread_l2", bus_l2.douta, c_ONES);
        rst_n = 1'b1;
        tick();
        tick();
        chk("rst_flush_l2", bus_l2.douta, c_ONES);
        chk("rst_flush_nc", bus_nc.douta, c_ONES);

`ifdef TRACE_SPRAM_BYTE_WRITE_EN
        wr(10'd7, 48'h0); tick();
        ena = 1'b1; wea = 6'b000001; addra = 10'd7; dina = c_ONES;
        tick();
        chk("byte_wf_merged", bus_wf.douta, 48'h0000_0000_00FF);
        rd(10'd7); tick();
        chk("byte_read", bus_nc.douta, 48'h0000_0000_00FF);
`endif

        ena = 1'b0; wea = '0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
